// File: rtl/control_fsm.sv
// control_fsm: multi-cycle sequencer for the 16-bit CPU datapath; arbitrates the single
// memory port between fetch and load/store. Define MEM_TIMEOUT_EN to build the bus timeout/FAULT path.
module control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic       cond_true,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       flags_we,
  output logic       alu_src_imm,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state_dbg
);

  localparam logic [4:0] OP_CMP     = 5'b01000;
  localparam logic [4:0] OP_CMPI    = 5'b01001;
  localparam logic [4:0] OP_BR      = 5'b01010;
  localparam logic [4:0] OP_BL      = 5'b01011;
  localparam logic [4:0] OP_LOAD    = 5'b01100;
  localparam logic [4:0] OP_LOAD_R  = 5'b01101;
  localparam logic [4:0] OP_STORE   = 5'b01110;
  localparam logic [4:0] OP_STORE_R = 5'b01111;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_CMP,
    CLS_BR,
    CLS_BL,
    CLS_LOAD,
    CLS_STORE
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_CMP, OP_CMPI:      op_class = CLS_CMP;
      OP_BR:                op_class = CLS_BR;
      OP_BL:                op_class = CLS_BL;
      OP_LOAD, OP_LOAD_R:   op_class = CLS_LOAD;
      OP_STORE, OP_STORE_R: op_class = CLS_STORE;
      default:              op_class = CLS_ALU;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [4:0] op);
    uses_imm = (op == OP_CMPI) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BR)   || (op == OP_BL);
  endfunction

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_cfg
    $error("control_fsm: TMO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e    state;
  state_e    state_next;
  state_e    retire_state;
  op_class_e cls;
  logic      tmo_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Any state change clears the count, so it restarts on every FETCH/MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state_next != state)
      tmo_cnt <= '0;
    else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_expire = (tmo_cnt == TMO_LAST);
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    flags_we     = 1'b0;
    alu_src_imm  = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    bus_err      = 1'b0;
    state_dbg    = state;
    cls          = op_class(opcode);
    // Halt is taken at the instruction boundary, so no fetch request is ever raised for it.
    retire_state = halt_req ? ST_HALT : ST_FETCH;

    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (tmo_expire) begin
          state_next = ST_FAULT;
        end
      end

      ST_DECODE: state_next = ST_EXEC;

      ST_EXEC: begin
        alu_src_imm = uses_imm(opcode);
        case (cls)
          CLS_CMP: begin
            flags_we   = 1'b1;
            instr_done = 1'b1;
            state_next = retire_state;
          end
          CLS_BR: begin
            pc_we      = cond_true;
            pc_src     = 1'b1;
            instr_done = 1'b1;
            state_next = retire_state;
          end
          CLS_BL: begin
            reg_we     = 1'b1;
            wb_sel     = WB_LINK;
            pc_we      = cond_true;
            pc_src     = 1'b1;
            instr_done = 1'b1;
            state_next = retire_state;
          end
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default: begin
            reg_we     = 1'b1;
            wb_sel     = WB_ALU;
            instr_done = 1'b1;
            state_next = retire_state;
          end
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            instr_done = 1'b1;
            state_next = retire_state;
          end else begin
            state_next = ST_WB;
          end
        end else if (tmo_expire) begin
          state_next = ST_FAULT;
        end
      end

      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = WB_MEM;
        instr_done = 1'b1;
        state_next = retire_state;
      end

      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_next = ST_FETCH;
      end

      ST_FAULT: begin
`ifdef MEM_TIMEOUT_EN
        bus_err = 1'b1;
`else
        state_next = ST_FETCH;
`endif
      end

      default: state_next = ST_FETCH;
    endcase

    // Outputs are forced quiet while reset is asserted, including mid-transfer.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      flags_we     = 1'b0;
      alu_src_imm  = 1'b0;
      instr_done   = 1'b0;
      halted       = 1'b0;
      bus_err      = 1'b0;
      state_dbg    = 3'd0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: vector table, hand sequences, and randomized instruction stream
// against a phase-level reference model. Timeout/FAULT case runs when MEM_TIMEOUT_EN is defined.
module tb_control_fsm;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TMO   = 4;
  localparam int MAX_WAIT = 2;
`else
  localparam int TB_TMO   = 255;
  localparam int MAX_WAIT = 5;
`endif

  localparam logic [4:0] OP_ADD     = 5'b00001;
  localparam logic [4:0] OP_CMP     = 5'b01000;
  localparam logic [4:0] OP_CMPI    = 5'b01001;
  localparam logic [4:0] OP_BR      = 5'b01010;
  localparam logic [4:0] OP_BL      = 5'b01011;
  localparam logic [4:0] OP_LOAD    = 5'b01100;
  localparam logic [4:0] OP_LOAD_R  = 5'b01101;
  localparam logic [4:0] OP_STORE   = 5'b01110;
  localparam logic [4:0] OP_STORE_R = 5'b01111;
  localparam logic [4:0] OP_UNK     = 5'b11111;

  localparam int K_ALU = 0, K_CMP = 1, K_BR = 2, K_BL = 3, K_LOAD = 4, K_STORE = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_we, pc_src, reg_we;
  logic [1:0] wb_sel;
  logic       flags_we, alu_src_imm, instr_done, halted, bus_err;
  logic [2:0] state_dbg;
  logic [16:0] act;

  int n_checks = 0;
  int n_errors = 0;

  control_fsm #(.TIMEOUT_CYCLES(TB_TMO), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_true(cond_true),
    .mem_ready(mem_ready), .halt_req(halt_req), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we), .alu_src_imm(alu_src_imm),
    .instr_done(instr_done), .halted(halted), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, mem_addr_sel, ir_load, pc_we, pc_src, reg_we, wb_sel,
                flags_we, alu_src_imm, instr_done, halted, bus_err, state_dbg};

  function automatic logic [16:0] ev(input int mreq, mwe, msel, irl, pcwe, pcsrc, rwe, wbs,
                                     input int fwe, imm, done, hlt, berr, st);
    return {1'(mreq), 1'(mwe), 1'(msel), 1'(irl), 1'(pcwe), 1'(pcsrc), 1'(rwe), 2'(wbs),
            1'(fwe), 1'(imm), 1'(done), 1'(hlt), 1'(berr), 3'(st)};
  endfunction

  function automatic int kind_of(input logic [4:0] op);
    if (op == OP_CMP || op == OP_CMPI)      return K_CMP;
    if (op == OP_BR)                        return K_BR;
    if (op == OP_BL)                        return K_BL;
    if (op == OP_LOAD || op == OP_LOAD_R)   return K_LOAD;
    if (op == OP_STORE || op == OP_STORE_R) return K_STORE;
    return K_ALU;
  endfunction

  // Expected output image of each instruction phase.
  function automatic logic [16:0] e_fetch(input int done);
    return ev(1, 0, 0, done, done, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_decode();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic logic [16:0] e_exec(input logic [4:0] op, input logic cnd);
    int k;
    int imm;
    k = kind_of(op);
    imm = (op == OP_CMPI || op == OP_LOAD || op == OP_STORE || k == K_BR || k == K_BL) ? 1 : 0;
    case (k)
      K_CMP:           return ev(0, 0, 0, 0, 0,   0, 0, 0, 1, imm, 1, 0, 0, 2);
      K_BR:            return ev(0, 0, 0, 0, cnd, 1, 0, 0, 0, imm, 1, 0, 0, 2);
      K_BL:            return ev(0, 0, 0, 0, cnd, 1, 1, 2, 0, imm, 1, 0, 0, 2);
      K_LOAD, K_STORE: return ev(0, 0, 0, 0, 0,   0, 0, 0, 0, imm, 0, 0, 0, 2);
      default:         return ev(0, 0, 0, 0, 0,   0, 1, 0, 0, imm, 1, 0, 0, 2);
    endcase
  endfunction
  function automatic logic [16:0] e_mem(input int store, input int done);
    return ev(1, store, 1, 0, 0, 0, 0, 0, 0, 0, done, 0, 0, 3);
  endfunction
  function automatic logic [16:0] e_wb();
    return ev(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 4);
  endfunction
  function automatic logic [16:0] e_halt();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [4:0] rnd5();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic check(input string name, input logic [16:0] a, input logic [16:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic step(input string name, input logic [4:0] op, input logic cnd,
                      input logic rdy, input logic hlt, input logic [16:0] e);
    @(negedge clk);
    opcode    = op;
    cond_true = cnd;
    mem_ready = rdy;
    halt_req  = hlt;
    #1;
    check(name, act, e);
  endtask

  // One instruction from its FETCH through retirement (and optional halt window).
  task automatic run_instr(input logic [4:0] op, input int fw, input int mw,
                           input bit hlt_after, input int hk);
    int k;
    logic cnd;
    k = kind_of(op);
    for (int i = 0; i < fw; i++) step("r_fetch_wait", rnd5(), rb(), 1'b0, rb(), e_fetch(0));
    step("r_fetch", rnd5(), rb(), 1'b1, rb(), e_fetch(1));
    step("r_decode", op, rb(), rb(), rb(), e_decode());
    cnd = rb();
    if (k == K_LOAD || k == K_STORE) begin
      step("r_exec", op, cnd, rb(), rb(), e_exec(op, cnd));
      for (int i = 0; i < mw; i++)
        step("r_mem_wait", op, rb(), 1'b0, rb(), e_mem(k == K_STORE, 0));
      if (k == K_STORE) begin
        step("r_mem_st", op, rb(), 1'b1, hlt_after, e_mem(1, 1));
      end else begin
        step("r_mem_ld", op, rb(), 1'b1, rb(), e_mem(0, 0));
        step("r_wb", op, rb(), rb(), hlt_after, e_wb());
      end
    end else begin
      step("r_exec", op, cnd, rb(), hlt_after, e_exec(op, cnd));
    end
    if (hlt_after) begin
      for (int i = 0; i < hk; i++) step("r_halt", rnd5(), rb(), rb(), 1'b1, e_halt());
      step("r_halt_rel", rnd5(), rb(), rb(), 1'b0, e_halt());
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        cnd;
    logic        rdy;
    logic        hlt;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [4:0] op, input logic cnd, input logic rdy,
                     input logic hlt, input logic [16:0] e);
    vec_t v;
    v.name = nm; v.op = op; v.cnd = cnd; v.rdy = rdy; v.hlt = hlt; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    // ALU op, zero-wait memory: ir_load@c0, writeback+done@c2, next fetch@c3
    add("alu_fetch",   OP_STORE, 1'b0, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("alu_decode",  OP_ADD,   1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("alu_exec",    OP_ADD,   1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,1,0,0,0,1,0,0,2));
    add("bl_fetch",    OP_ADD,   1'b0, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("bl_decode",   OP_BL,    1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("bl_exec",     OP_BL,    1'b1, 1'b0, 1'b0, ev(0,0,0,0,1,1,1,2,0,1,1,0,0,2));
    add("br_fetch",    OP_BL,    1'b1, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("br_decode",   OP_BR,    1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("br_exec_nt",  OP_BR,    1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,0,0,1,1,0,0,2));
    add("cmpi_fetch",  OP_BR,    1'b0, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("cmpi_decode", OP_CMPI,  1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("cmpi_exec",   OP_CMPI,  1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,1,1,1,0,0,2));
    add("str_fetch",   OP_CMPI,  1'b0, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("str_decode",  OP_STORE_R, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("str_exec",    OP_STORE_R, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
    add("str_mem",     OP_STORE_R, 1'b0, 1'b1, 1'b0, ev(1,1,1,0,0,0,0,0,0,0,1,0,0,3));
    add("unk_fetch",   OP_LOAD,  1'b0, 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0,0,0));
    add("unk_decode",  OP_UNK,   1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("unk_exec",    OP_UNK,   1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,0,0,0,1,0,0,2));

    // Reset held low with mem_ready high: everything quiet
    halt_req = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_LOAD;
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      opcode = rnd5();
      cond_true = rb();
      #1;
      check("rst_hold", act, 17'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_release", act, e_fetch(0));

    foreach (tbl[i]) step(tbl[i].name, tbl[i].op, tbl[i].cnd, tbl[i].rdy, tbl[i].hlt, tbl[i].exp);

    // Load with three MEM wait cycles: 8 cycles from fetch to retirement
    step("ld_fetch",  OP_ADD,  1'b0, 1'b1, 1'b0, e_fetch(1));
    step("ld_decode", OP_LOAD, 1'b0, 1'b0, 1'b0, e_decode());
    step("ld_exec",   OP_LOAD, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,1,0,0,0,2));
    for (int i = 0; i < 3; i++) step("ld_mem_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, e_mem(0, 0));
    step("ld_mem_done", OP_LOAD, 1'b0, 1'b1, 1'b0, e_mem(0, 0));
    step("ld_wb",       OP_LOAD, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,1,0,0,1,0,0,4));
    step("ld_next",     OP_LOAD, 1'b0, 1'b0, 1'b0, e_fetch(0));

    // halt_req raised during a store's MEM: store retires, then HALT, then release
    step("sth_fetch",  OP_ADD,   1'b0, 1'b1, 1'b0, e_fetch(1));
    step("sth_decode", OP_STORE, 1'b0, 1'b0, 1'b0, e_decode());
    step("sth_exec",   OP_STORE, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,1,0,0,0,2));
    step("sth_mem_w",  OP_STORE, 1'b0, 1'b0, 1'b1, e_mem(1, 0));
    step("sth_mem",    OP_STORE, 1'b0, 1'b1, 1'b1, e_mem(1, 1));
    step("sth_halt0",  OP_STORE, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,0,1,0,5));
    step("sth_halt1",  OP_CMP,   1'b1, 1'b1, 1'b1, e_halt());
    step("sth_release",OP_CMP,   1'b1, 1'b0, 1'b0, e_halt());
    step("sth_fetch2", OP_CMP,   1'b0, 1'b0, 1'b0, e_fetch(0));

    // Reset asserted in the middle of a load transfer drops mem_req at once
    step("rm_fetch",  OP_ADD,    1'b0, 1'b1, 1'b0, e_fetch(1));
    step("rm_decode", OP_LOAD_R, 1'b0, 1'b0, 1'b0, e_decode());
    step("rm_exec",   OP_LOAD_R, 1'b0, 1'b0, 1'b0, e_exec(OP_LOAD_R, 1'b0));
    step("rm_mem_w",  OP_LOAD_R, 1'b0, 1'b0, 1'b0, e_mem(0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rm_reset", act, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rm_release", act, e_fetch(0));

    for (int n = 0; n < 150; n++) begin
      run_instr(rnd5(), $urandom_range(0, MAX_WAIT), $urandom_range(0, MAX_WAIT),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

`ifdef MEM_TIMEOUT_EN
    // mem_ready stuck low in FETCH: FAULT after TB_TMO cycles, sticky until reset
    for (int i = 0; i < TB_TMO; i++) step("tmo_wait", rnd5(), rb(), 1'b0, 1'b0, e_fetch(0));
    for (int i = 0; i < 4; i++)
      step("tmo_fault", rnd5(), rb(), rb(), rb(), ev(0,0,0,0,0,0,0,0,0,0,0,0,1,6));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("tmo_reset", act, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    halt_req = 1'b0;
    #1;
    check("tmo_release", act, e_fetch(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
